// File: rtl/video_stitch_pkg.sv
// Shared types and AXI encodings for the video stitching write path.
package video_stitch_pkg;

   typedef enum logic [1:0] {StIdle, StAw, StW, StB} wr_state_e;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/video_wr_arbiter_if.sv
// AXI4 write-only bus (AW/W/B) between the arbiter (master) and frame memory (slave).
interface video_wr_arbiter_if #(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 128,
   parameter int unsigned C_M_AXI_ID_WIDTH   = 1
);
   logic [C_M_AXI_ID_WIDTH-1:0]     awid;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]                      awlen;
   logic [2:0]                      awsize;
   logic [1:0]                      awburst;
   logic                            awvalid;
   logic                            awready;
   logic [C_M_AXI_DATA_WIDTH-1:0]   wdata;
   logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb;
   logic                            wlast;
   logic                            wvalid;
   logic                            wready;
   logic [1:0]                      bresp;
   logic                            bvalid;
   logic                            bready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      output wdata, wstrb, wlast, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      input  wdata, wstrb, wlast, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requester after ptr_i, wrapping modulo NUM_CH.
module rr_pick #(
   parameter int unsigned NUM_CH  = 3,
   parameter int unsigned GRANT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0]  req_i,
   input  logic [GRANT_W-1:0] ptr_i,
   output logic [GRANT_W-1:0] grant_o,
   output logic               valid_o
);

   if (NUM_CH == 1) begin : g_single
      logic unused_ptr;
      assign unused_ptr = ^ptr_i;
      assign grant_o    = '0;
      assign valid_o    = req_i[0];
   end else begin : g_multi
      always_comb begin
         logic [GRANT_W-1:0] idx;
         grant_o = '0;
         valid_o = 1'b0;
         idx     = ptr_i;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = (idx == GRANT_W'(NUM_CH - 1)) ? '0 : idx + GRANT_W'(1);
            if (!valid_o && req_i[idx]) begin
               valid_o = 1'b1;
               grant_o = idx;
            end
         end
      end
   end

endmodule

// File: rtl/video_wr_arbiter.sv
// N-channel round-robin AXI4 write arbiter; one fixed-length burst in flight at a time.
// Optional sticky error flags on non-OKAY BRESP when VIDEO_WR_ARB_ERR_EN is defined.
module video_wr_arbiter
   import video_stitch_pkg::*;
#(
   parameter int unsigned NUM_CH             = 3,
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 128,
   parameter int unsigned C_M_AXI_BURST_LEN  = 16,
   parameter int unsigned C_M_AXI_ID_WIDTH   = 1,
   localparam int unsigned GRANT_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                                   M_AXI_ACLK,
   input  logic                                   M_AXI_ARESET,
   input  logic [NUM_CH-1:0]                      ch_req,
   input  logic [NUM_CH*C_M_AXI_ADDR_WIDTH-1:0]   ch_addr,
   input  logic [NUM_CH*C_M_AXI_DATA_WIDTH-1:0]   ch_rd_data,
   output logic [NUM_CH-1:0]                      ch_rd_en,
   output logic [NUM_CH-1:0]                      ch_ack,
   output logic [GRANT_W-1:0]                     grant_id,
   output logic                                   busy,
   output logic [NUM_CH-1:0]                      err_flags,
   video_wr_arbiter_if.master                     m_axi
);

   localparam int unsigned BEAT_W = (C_M_AXI_BURST_LEN > 1) ? $clog2(C_M_AXI_BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(C_M_AXI_BURST_LEN - 1);
   localparam logic [NUM_CH-1:0] CH_ONE    = NUM_CH'(1);

   wr_state_e                     state_q, state_d;
   logic [GRANT_W-1:0]            grant_q, grant_d;
   logic [GRANT_W-1:0]            last_q, last_d;
   logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [BEAT_W-1:0]             beat_q, beat_d;
   logic [GRANT_W-1:0]            pick_idx;
   logic                          pick_valid;
   logic                          aw_valid, w_valid, w_last, b_ready;

   rr_pick #(
      .NUM_CH  (NUM_CH),
      .GRANT_W (GRANT_W)
   ) u_rr_pick (
      .req_i   (ch_req),
      .ptr_i   (last_q),
      .grant_o (pick_idx),
      .valid_o (pick_valid)
   );

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      awaddr_d = awaddr_q;
      beat_d   = beat_q;
      ch_rd_en = '0;
      ch_ack   = '0;
      aw_valid = 1'b0;
      w_valid  = 1'b0;
      b_ready  = 1'b0;
      w_last   = (state_q == StW) && (beat_q == LAST_BEAT);
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               grant_d  = pick_idx;
               awaddr_d = ch_addr[int'(pick_idx)*C_M_AXI_ADDR_WIDTH +: C_M_AXI_ADDR_WIDTH];
               state_d  = StAw;
            end
         end
         StAw: begin
            aw_valid = 1'b1;
            if (m_axi.awready) state_d = StW;
         end
         StW: begin
            w_valid = 1'b1;
            if (m_axi.wready) begin
               ch_rd_en = CH_ONE << grant_q;
               if (w_last) begin
                  beat_d  = '0;
                  state_d = StB;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         StB: begin
            b_ready = 1'b1;
            if (m_axi.bvalid) begin
               ch_ack  = CH_ONE << grant_q;
               last_d  = grant_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         last_q   <= GRANT_W'(NUM_CH - 1);
         awaddr_q <= '0;
         beat_q   <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         awaddr_q <= awaddr_d;
         beat_q   <= beat_d;
      end
   end

`ifdef VIDEO_WR_ARB_ERR_EN
   logic [NUM_CH-1:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (state_q == StB && m_axi.bvalid && m_axi.bresp != AXI_RESP_OKAY) begin
         err_d = err_q | (CH_ONE << grant_q);
      end
   end

   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) err_q <= '0;
      else              err_q <= err_d;
   end

   assign err_flags = err_q;
`else
   logic unused_bresp;
   assign unused_bresp = ^m_axi.bresp;
   assign err_flags    = '0;
`endif

   // WDATA is the granted FIFO head, so a stalled beat stays put until the slave takes it.
   assign m_axi.awid    = '0;
   assign m_axi.awaddr  = awaddr_q;
   assign m_axi.awlen   = 8'(C_M_AXI_BURST_LEN - 1);
   assign m_axi.awsize  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
   assign m_axi.awburst = AXI_BURST_INCR;
   assign m_axi.awvalid = aw_valid;
   assign m_axi.wdata   = ch_rd_data[int'(grant_q)*C_M_AXI_DATA_WIDTH +: C_M_AXI_DATA_WIDTH];
   assign m_axi.wstrb   = '1;
   assign m_axi.wlast   = w_last;
   assign m_axi.wvalid  = w_valid;
   assign m_axi.bready  = b_ready;

   assign grant_id = grant_q;
   assign busy     = (state_q != StIdle);

endmodule

// File: doc/video_wr_arbiter.md
# video_wr_arbiter

Parametrised N-channel AXI4 write arbiter for the video stitching datapath. It time-multiplexes fixed-length write bursts from NUM_CH camera write channels onto one AXI4-Full master write interface, with round-robin fairness. Each channel supplies a first-word-fall-through (FWFT) FIFO read port and a burst start address. The block sits between the per-camera line buffers and the frame memory. It replaces the fixed three-source write path.

## Interface
- NUM_CH, 3, number of write channels (≥1)
- C_M_AXI_ADDR_WIDTH, 32, AXI address width
- C_M_AXI_DATA_WIDTH, 128, AXI data width (power of 2, ≥32)
- C_M_AXI_BURST_LEN, 16, beats per burst (1–256)
- C_M_AXI_ID_WIDTH, 1, AXI ID width
- M_AXI_ACLK  in  1  sole clock
- M_AXI_ARESET  in  1  reset, asynchronous, active-high
- ch_req  in  NUM_CH  channel holds ≥1 full burst and requests a write
- ch_addr  in  NUM_CH*ADDR  per-channel burst start address; stable while ch_req is high
- ch_rd_data  in  NUM_CH*DATA  per-channel FWFT FIFO head word
- ch_rd_en  out  NUM_CH  FIFO pop strobe
- ch_ack  out  NUM_CH  one-cycle pulse when the channel's burst response is accepted
- grant_id  out  max(1,$clog2(NUM_CH))  currently or last granted channel
- busy  out  1  high in any state other than IDLE
- err_flags  out  NUM_CH  sticky write-error flags (see Configuration)
- M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out; M_AXI_AWREADY  in
- M_AXI_WDATA/WSTRB/WLAST/WVALID  out; M_AXI_WREADY  in
- M_AXI_BRESP[1:0], M_AXI_BVALID  in; M_AXI_BREADY  out

## Operation
- FSM states: IDLE → AW → W → B → IDLE.
- IDLE:
  - If ch_req is non-zero, the rr_pick sub-module searches from last_grant+1 (mod NUM_CH) and selects the first requester.
  - Latch grant and ch_addr[grant] into AWADDR, then enter AW.
- AW: AWVALID=1. On AWREADY, go to W.
- W:
  - WVALID=1.
  - WDATA=ch_rd_data[grant], muxed combinationally from the FWFT head.
  - ch_rd_en[grant]=WVALID&WREADY.
  - The beat counter increments on each handshake. WLAST=(count==BURST_LEN-1).
  - On the last handshake, go to B.
- B:
  - BREADY=1.
  - On BVALID: pulse ch_ack[grant], set last_grant=grant, return to IDLE.
- Constants:
  - AWLEN=BURST_LEN-1
  - AWSIZE=$clog2(DATA/8)
  - AWBURST=2'b01 (INCR)
  - AWID=0
  - WSTRB=all ones
- Bursts are never split and never interleaved. Only one transaction is outstanding at a time.

## Timing
- Reset values:
  - All outputs 0: AWVALID, WVALID, WLAST, BREADY, ch_rd_en, ch_ack, busy, err_flags, grant_id.
  - FSM=IDLE, beat counter=0.
  - last_grant=NUM_CH-1, so channel 0 wins first.
- Latency and throughput:
  - AWVALID rises 1 cycle after ch_req is sampled in IDLE.
  - Minimum burst period with zero-wait slave: BURST_LEN+3 cycles.
- Handshakes:
  - AWVALID and WVALID/WDATA are held until their ready is seen. No valid is ever retracted.
  - BVALID during AW or W is ignored, since BREADY is low.
- Boundary conditions:
  - ch_req dropping after grant: the burst completes regardless. Channels must not drop a request once it is granted.
  - Simultaneous requests from all channels: strict rotation 0,1,2,0,…
  - A single persistent requester is re-granted every burst.
  - Reset mid-burst: all valids and BREADY drop asynchronously. No ch_ack is issued for the aborted burst.
  - NUM_CH=1: rr_pick degenerates to the single channel.

## Configuration
- `VIDEO_WR_ARB_ERR_EN` defined:
  - In B, an accepted response with BRESP≠2'b00 sets err_flags[grant].
  - The flag is sticky until reset.
  - ch_ack still pulses.
- `VIDEO_WR_ARB_ERR_EN` undefined: err_flags is tied to 0 and BRESP is ignored.

## Structure
- Package video_stitch_pkg holds:
  - FSM state enum
  - AXI_BURST_INCR
  - AXI_RESP_OKAY
  - AXI_RESP_SLVERR
- Sub-module rr_pick: combinational round-robin search taking req vector and pointer, returning grant index and valid.

## Test plan
- Reset check: assert reset → every output listed above is 0; first simultaneous request from all channels → grant_id=0.
- Single burst: ch_req=3'b010, ch_addr[1]=0x1000_0000, slave always ready →
  - AWADDR=0x1000_0000, AWLEN=15, AWSIZE=4
  - 16 W beats in FIFO order, WLAST on beat 16
  - exactly 16 ch_rd_en[1] pulses
  - ch_ack[1] 1 cycle wide on BVALID
- All three channels requesting continuously for 6 bursts → grant sequence 0,1,2,0,1,2; each AWVALID rises only after the previous ch_ack.
- WREADY toggling every other cycle and AWREADY delayed 5 cycles → AWVALID, WVALID and WDATA held stable; 16 pops total; data order preserved.
- Reset asserted at beat 8 of a channel-2 burst → AWVALID, WVALID and BREADY drop immediately with no ch_ack; after release with all channels requesting, channel 0 is granted.
- With `VIDEO_WR_ARB_ERR_EN`: BRESP=2'b10 on a channel-2 burst → err_flags=3'b100, still set after subsequent OKAY bursts. Without the macro: err_flags=0.
